// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave bridging serial frames onto a parallel register interface.
// Build option: define SPI_BURST_EN for auto-incrementing multi-word bursts.
module spi_reg_bridge #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  output logic              data_write,
  output logic              data_read,
  output logic              busy
);

  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    ADDR,
    DATA
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
  logic                   cs_d, sck_d, mosi_d;
  logic                   cs_s, sck_s;
  logic                   rise, fall, cs_fall;

  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_sh;
  logic [DATA_W-1:0] rx;
  logic [DATA_W-1:0] tx;
  logic              is_write;
  logic              done;
  logic              word_pend, inc_pend, rd_pend, load_pend;

  // Input synchronisers plus one delay stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync   <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_d      <= 1'b1;
      sck_d     <= 1'b0;
      mosi_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_d      <= cs_sync[SYNC_STAGES-1];
      sck_d     <= sck_sync[SYNC_STAGES-1];
      mosi_d    <= mosi_sync[SYNC_STAGES-1];
    end
  end

  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign sck_s   = sck_sync[SYNC_STAGES-1];
  assign rise    = sck_s & ~sck_d;
  assign fall    = ~sck_s & sck_d;
  assign cs_fall = ~cs_s & cs_d;

  // State register; busy tracks the registered state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    if (cs_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (cs_fall) state_d = CMD;
        CMD:     if (rise) state_d = ADDR;
        ADDR:    if (rise && (cnt == CNT_W'(ADDR_W - 1))) state_d = DATA;
        DATA:    state_d = DATA;
        default: state_d = IDLE;
      endcase
    end
  end

  // Shift/datapath; strobes are pipelined one cycle behind the sampled bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address    <= '0;
      data_in    <= '0;
      data_write <= 1'b0;
      data_read  <= 1'b0;
      spi_miso   <= 1'b0;
      cnt        <= '0;
      addr_sh    <= '0;
      rx         <= '0;
      tx         <= '0;
      is_write   <= 1'b0;
      done       <= 1'b0;
      word_pend  <= 1'b0;
      inc_pend   <= 1'b0;
      rd_pend    <= 1'b0;
      load_pend  <= 1'b0;
    end else begin
      data_write <= 1'b0;
      data_read  <= 1'b0;
      word_pend  <= 1'b0;
      inc_pend   <= 1'b0;
      rd_pend    <= 1'b0;
      load_pend  <= 1'b0;

      if (cs_s) begin
        // A raised chip select outranks a coincident SCK edge
        cnt      <= '0;
        done     <= 1'b0;
        tx       <= '0;
        spi_miso <= 1'b0;
      end else if (rise) begin
        case (state_q)
          CMD: begin
            is_write <= mosi_d;
            cnt      <= '0;
          end
          ADDR: begin
            addr_sh <= ADDR_W'({addr_sh, mosi_d});
            if (cnt == CNT_W'(ADDR_W - 1)) begin
              address <= ADDR_W'({addr_sh, mosi_d});
              cnt     <= '0;
              rd_pend <= ~is_write;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          DATA: begin
            if (!done) begin
              rx <= DATA_W'({rx, mosi_d});
              if (cnt == CNT_W'(DATA_W - 1)) begin
                cnt       <= '0;
                word_pend <= 1'b1;
`ifndef SPI_BURST_EN
                done      <= 1'b1;
`endif
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          default: ;
        endcase
      end else if (fall && (state_q == DATA)) begin
        // Zero fill means MISO returns to 0 once a word has been shifted out
        spi_miso <= tx[DATA_W-1];
        tx       <= tx << 1;
      end

      if (word_pend) begin
        if (is_write) begin
          data_write <= 1'b1;
          data_in    <= rx;
        end
`ifdef SPI_BURST_EN
        if (is_write) begin
          inc_pend <= 1'b1;
        end else begin
          address <= address + ADDR_W'(1);
          rd_pend <= 1'b1;
        end
`endif
      end

      if (inc_pend) address <= address + ADDR_W'(1);

      if (rd_pend) begin
        data_read <= 1'b1;
        load_pend <= 1'b1;
      end

      if (load_pend) tx <= data_out;
    end
  end

endmodule
